// File: rtl/des_pkg.sv
// Shared definitions for the serial DES S-box unit: data widths, FSM states,
// the eight S-box tables and a small bit-order helper.
package des_pkg;

  localparam int unsigned DATA_W   = 48;  // expanded half / round key width
  localparam int unsigned OUT_W    = 32;  // substituted word width
  localparam int unsigned GROUP_W  = 6;   // bits per S-box input group
  localparam int unsigned NIBBLE_W = 4;   // bits per S-box output
  localparam int unsigned NUM_SBOX = 8;   // number of S-boxes
  localparam int unsigned CNT_W    = 3;   // group counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // One S-box row: element 0 is column 0 (leftmost nibble of the literal).
  typedef logic [0:15][NIBBLE_W-1:0] sbox_row_t;

  // S-box table indexed [sbox][row][col], standard DES contents.
  localparam sbox_row_t SBOX_TABLE [0:7][0:3] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Output words carry DES bit 1 at the lowest index, so table values
  // (MSB-first numbers) are mirrored before being placed in the word.
  function automatic logic [NIBBLE_W-1:0] rev_nibble(input logic [NIBBLE_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational single S-box lookup.
// Ports:
//   i_sbox_idx : S-box number minus one (0..7)
//   i_group    : 6-bit input group, index 0 is the first DES bit of the group
//   o_value_c  : 4-bit S-box value, ordinary MSB-first number
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [CNT_W-1:0]    i_sbox_idx,
  input  logic [GROUP_W-1:0]  i_group,
  output logic [NIBBLE_W-1:0] o_value_c
);

  logic [1:0] row_c;
  logic [3:0] col_c;

  // Row comes from the outer bits, column from the inner four, first bit as MSB.
  assign row_c     = {i_group[0], i_group[5]};
  assign col_c     = {i_group[1], i_group[2], i_group[3], i_group[4]};
  assign o_value_c = SBOX_TABLE[i_sbox_idx][row_c][col_c];

endmodule

// File: rtl/des_sbox_serial_unit.sv
// Serial DES S-box stage: XORs the expanded right half with the round key,
// resolves SBOXES_PER_CYCLE S-box groups per clock and returns the 32-bit
// substituted word (before the P-box) over a valid/ready handshake.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_valid / o_ready         : upstream handshake (o_ready high only in IDLE)
//   i_expanded_data           : 48-bit expansion output, index 0 = DES bit 1
//   i_round_key               : 48-bit subkey, same bit order
//   o_valid / i_ready         : downstream handshake
//   o_sbox_data               : S1..S8 outputs, nibble k at [4k+3:4k], value MSB at 4k
module des_sbox_serial_unit
  import des_pkg::*;
#(
  parameter int unsigned SBOXES_PER_CYCLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_expanded_data,
  input  logic [DATA_W-1:0] i_round_key,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_sbox_data
);

  // Reject unsupported group counts at elaboration.
  if (!(SBOXES_PER_CYCLE == 1 || SBOXES_PER_CYCLE == 2 ||
        SBOXES_PER_CYCLE == 4 || SBOXES_PER_CYCLE == 8)) begin : g_bad_param
    $error("des_sbox_serial_unit: SBOXES_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // Counter value during the cycle that resolves group 7.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SBOX - SBOXES_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(SBOXES_PER_CYCLE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [OUT_W-1:0]    res_q, res_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic [CNT_W-1:0]    lk_idx   [SBOXES_PER_CYCLE];
  logic [GROUP_W-1:0]  lk_grp   [SBOXES_PER_CYCLE];
  logic [NIBBLE_W-1:0] lk_val   [SBOXES_PER_CYCLE];

  // One lookup slice per group resolved this cycle.
  for (genvar j = 0; j < SBOXES_PER_CYCLE; j++) begin : g_lookup
    assign lk_idx[j] = cnt_q + CNT_W'(j);
    assign lk_grp[j] = x_q[GROUP_W*lk_idx[j] +: GROUP_W];

    des_sbox_lookup u_lookup (
      .i_sbox_idx (lk_idx[j]),
      .i_group    (lk_grp[j]),
      .o_value_c  (lk_val[j])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          x_d     = i_expanded_data ^ i_round_key;
          res_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < int'(SBOXES_PER_CYCLE); j++) begin
          res_d[NIBBLE_W*lk_idx[j] +: NIBBLE_W] = rev_nibble(lk_val[j]);
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Handshake flags are registered copies of the next state.
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_sbox_data = res_q;

endmodule

// File: tb/tb_des_sbox_serial_unit.sv
// Directed bench for des_sbox_serial_unit. Four instances (1, 2, 4, 8 groups
// per cycle) share every input; test vectors are written in DES string order
// and mirrored into the index-0-first bus convention.
module tb_des_sbox_serial_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        rdy_in;
  logic [47:0] exp_data;
  logic [47:0] key;

  logic        o_ready [4];
  logic        o_valid [4];
  logic [31:0] o_data  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_sbox_serial_unit #(.SBOXES_PER_CYCLE(1)) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[0]),
    .i_expanded_data(exp_data), .i_round_key(key), .o_valid(o_valid[0]),
    .i_ready(rdy_in), .o_sbox_data(o_data[0]));
  des_sbox_serial_unit #(.SBOXES_PER_CYCLE(2)) u_n2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[1]),
    .i_expanded_data(exp_data), .i_round_key(key), .o_valid(o_valid[1]),
    .i_ready(rdy_in), .o_sbox_data(o_data[1]));
  des_sbox_serial_unit #(.SBOXES_PER_CYCLE(4)) u_n4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[2]),
    .i_expanded_data(exp_data), .i_round_key(key), .o_valid(o_valid[2]),
    .i_ready(rdy_in), .o_sbox_data(o_data[2]));
  des_sbox_serial_unit #(.SBOXES_PER_CYCLE(8)) u_n8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready[3]),
    .i_expanded_data(exp_data), .i_round_key(key), .o_valid(o_valid[3]),
    .i_ready(rdy_in), .o_sbox_data(o_data[3]));

  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word on all instances and check each one's latency and result.
  task automatic run_latency(input string tag, input logic [31:0] expected);
    valid = 1'b1;
    step();
    valid    = 1'b0;
    exp_data = '0;
    key      = '0;
    check({tag, "_busy_ready"}, 32'(o_ready[0]), 32'd0);
    for (int c = 1; c <= 9; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_n%0d_valid_c%0d", tag, 1 << i, c),
              32'(o_valid[i]), 32'(c == (8 >> i)));
        if (c == (8 >> i))
          check($sformatf("%s_n%0d_data", tag, 1 << i), o_data[i], expected);
      end
    end
  endtask

  localparam logic [47:0] E_R0   = 48'h7A15557A1555;
  localparam logic [47:0] K1     = 48'h1B02EFFC7072;
  localparam logic [31:0] RES_R1 = 32'h5C82B597;
  localparam logic [31:0] RES_Z  = 32'hEFA72C4D;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    rdy_in   = 1'b1;
    exp_data = '0;
    key      = '0;
    step();
    step();

    // Reset state on every instance.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_valid_n%0d", 1 << i), 32'(o_valid[i]), 32'd0);
      check($sformatf("rst_ready_n%0d", 1 << i), 32'(o_ready[i]), 32'd1);
      check($sformatf("rst_data_n%0d", 1 << i), o_data[i], 32'd0);
    end
    rst = 1'b0;
    step();

    // Standard round-1 vector on all group counts.
    exp_data = rev48(E_R0);
    key      = rev48(K1);
    run_latency("r1", rev32(RES_R1));
    step();
    check("r1_idle_ready", 32'(o_ready[0]), 32'd1);

    // Zero vector.
    exp_data = '0;
    key      = '0;
    run_latency("zero", rev32(RES_Z));
    step();

    // Backpressure in DONE.
    rdy_in   = 1'b0;
    exp_data = rev48(E_R0);
    key      = rev48(K1);
    valid    = 1'b1;
    step();
    valid = 1'b0;
    repeat (8) step();
    check("bp_valid_rise", 32'(o_valid[0]), 32'd1);
    for (int s = 1; s <= 5; s++) begin
      step();
      check($sformatf("bp_valid_s%0d", s), 32'(o_valid[0]), 32'd1);
      check($sformatf("bp_data_s%0d", s), o_data[0], rev32(RES_R1));
      check($sformatf("bp_ready_s%0d", s), 32'(o_ready[0]), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    check("bp_valid_drop", 32'(o_valid[0]), 32'd0);
    check("bp_idle_ready", 32'(o_ready[0]), 32'd1);
    repeat (2) step();

    // Input hold-off: i_valid and data toggle while busy.
    exp_data = '0;
    key      = '0;
    valid    = 1'b1;
    step();
    for (int c = 1; c <= 7; c++) begin
      valid    = (c % 2) == 1;
      exp_data = rev48(E_R0);
      key      = rev48(K1);
      step();
      check($sformatf("hold_ready_c%0d", c), 32'(o_ready[0]), 32'd0);
    end
    valid = 1'b0;
    step();
    check("hold_valid", 32'(o_valid[0]), 32'd1);
    check("hold_data", o_data[0], rev32(RES_Z));
    step();
    check("hold_valid_drop", 32'(o_valid[0]), 32'd0);
    check("hold_idle_ready", 32'(o_ready[0]), 32'd1);
    step();
    check("hold_no_extra_accept", 32'(o_ready[0]), 32'd1);
    repeat (10) step();

    // Reset in the middle of BUSY (counter at 3).
    exp_data = rev48(E_R0);
    key      = rev48(K1);
    valid    = 1'b1;
    step();
    valid = 1'b0;
    repeat (3) step();
    check("mid_busy_ready", 32'(o_ready[0]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(o_valid[0]), 32'd0);
    check("mid_rst_ready", 32'(o_ready[0]), 32'd1);
    check("mid_rst_data", o_data[0], 32'd0);
    check("mid_rst_data_n8", o_data[3], 32'd0);
    exp_data = '0;
    key      = '0;
    run_latency("after_rst", rev32(RES_Z));
    step();

    // Back-to-back: valid held, ready held, accepts every 10 cycles at N=1.
    exp_data = '0;
    key      = '0;
    valid    = 1'b1;
    step();
    exp_data = rev48(E_R0);
    key      = rev48(K1);
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("b2b_a_valid_c%0d", c), 32'(o_valid[0]), 32'(c == 8));
      check($sformatf("b2b_a_ready_c%0d", c), 32'(o_ready[0]), 32'(c == 9));
      if (c == 8) check("b2b_a_data", o_data[0], rev32(RES_Z));
    end
    valid    = 1'b0;
    exp_data = '0;
    key      = '0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("b2b_b_valid_c%0d", c), 32'(o_valid[0]), 32'(c == 8));
      if (c == 8) check("b2b_b_data", o_data[0], rev32(RES_R1));
    end
    check("b2b_end_ready", 32'(o_ready[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
